// File: rtl/hdmi_frame_capture_ctrl.sv
// Frame capture sequencer between the scaler write stream and the frame-buffer BRAM.
// Starts writes on a vsync edge, holds a completed frame until the consumer releases it.
module hdmi_frame_capture_ctrl #(
    parameter int FRAME_PIXELS   = 153600,
    parameter int VS_ACTIVE_HIGH = 1,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic        pclk,
    input  logic        rstb,
    input  logic        vsync,
    input  logic        in_ena,
    input  logic [23:0] in_addr,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        cap_req,
    input  logic        cont_mode,
    input  logic        frame_release,
    output logic        wr_en,
    output logic [23:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        frame_ready,
    output logic        busy,
    output logic [23:0] pix_count,
    output logic [15:0] frame_cnt,
    output logic        err_short,
    output logic        err_timeout,
    output logic [1:0]  state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]   FP      = 24'(FRAME_PIXELS);
    localparam logic [23:0]   FP_LAST = 24'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_READY   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          vs_q;
    logic          fs;
    logic          in_ok;
    logic          accept;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [23:0]   pix_n;
    logic [15:0]   fcnt_n;
    logic          err_short_n, err_to_n;

    // Frame start is an edge between last cycle's vsync and the live input.
    assign fs        = (VS_ACTIVE_HIGH != 0) ? (vsync & ~vs_q) : (~vsync & vs_q);
    assign in_ok     = in_ena & (in_addr < FP);
    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        to_cnt_n    = to_cnt;
        pix_n       = pix_count;
        fcnt_n      = frame_cnt;
        err_short_n = err_short;
        err_to_n    = err_timeout;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cap_req | cont_mode) begin
                    err_short_n = 1'b0;
                    err_to_n    = 1'b0;
                    to_cnt_n    = '0;
                    state_n     = S_ARM;
                end
            end
            S_ARM: begin
                if (fs) begin
                    pix_n    = '0;
                    to_cnt_n = '0;
                    state_n  = S_CAPTURE;
                end else if (to_cnt == TO_LAST) begin
                    err_to_n = 1'b1;
                    to_cnt_n = '0;
                    state_n  = S_IDLE;
                end else begin
                    to_cnt_n = to_cnt + TW'(1);
                end
            end
            S_CAPTURE: begin
                // The completing write takes priority over a coincident frame start.
                if (in_ok && pix_count == FP_LAST) begin
                    accept  = 1'b1;
                    pix_n   = pix_count + 24'd1;
                    fcnt_n  = frame_cnt + 16'd1;
                    state_n = S_READY;
                end else if (fs) begin
                    err_short_n = 1'b1;
                    pix_n       = '0;
                    state_n     = cont_mode ? S_CAPTURE : S_IDLE;
                end else if (in_ok) begin
                    accept = 1'b1;
                    pix_n  = pix_count + 24'd1;
                end
            end
            S_READY: begin
                if (frame_release) begin
                    to_cnt_n = '0;
                    state_n  = cont_mode ? S_ARM : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb) begin
            state       <= S_IDLE;
            vs_q        <= 1'b0;
            to_cnt      <= '0;
            pix_count   <= '0;
            frame_cnt   <= '0;
            err_short   <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            frame_ready <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            state       <= state_n;
            vs_q        <= vsync;
            to_cnt      <= to_cnt_n;
            pix_count   <= pix_n;
            frame_cnt   <= fcnt_n;
            err_short   <= err_short_n;
            err_timeout <= err_to_n;
            busy        <= (state_n == S_ARM) || (state_n == S_CAPTURE);
            frame_ready <= (state_n == S_READY);
            wr_en       <= accept;
            if (accept) begin
                wr_addr <= in_addr;
                wr_data <= {in_r, in_g, in_b};
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_capture_ctrl.sv
// Bench for hdmi_frame_capture_ctrl with a 16-pixel frame and 64-cycle arm timeout.
// Table vectors drive pixel streams; a write scoreboard checks every BRAM write and its latency.
module tb_hdmi_frame_capture_ctrl;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_CAP = 2'd2, ST_READY = 2'd3;
    localparam int W = 80;

    logic        pclk, rstb, vsync, in_ena, cap_req, cont_mode, frame_release;
    logic [23:0] in_addr;
    logic [7:0]  in_r, in_g, in_b;
    logic        wr_en, frame_ready, busy, err_short, err_timeout;
    logic [23:0] wr_addr, wr_data, pix_count;
    logic [15:0] frame_cnt;
    logic [1:0]  state_dbg;

    typedef struct {
        logic [23:0] addr;
        logic [23:0] rgb;
        logic        exp_wr;
        logic [23:0] exp_pix;
    } vec_t;

    vec_t        tab[$];
    logic [W-1:0] exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    hdmi_frame_capture_ctrl #(
        .FRAME_PIXELS(16),
        .VS_ACTIVE_HIGH(1),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .pclk(pclk), .rstb(rstb), .vsync(vsync), .in_ena(in_ena), .in_addr(in_addr),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .cap_req(cap_req), .cont_mode(cont_mode),
        .frame_release(frame_release), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ready(frame_ready), .busy(busy), .pix_count(pix_count), .frame_cnt(frame_cnt),
        .err_short(err_short), .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // driver
    task automatic drive_pix(input logic [23:0] addr, input logic [23:0] rgb, input logic expect_wr);
        in_ena  = 1'b1;
        in_addr = addr;
        {in_r, in_g, in_b} = rgb;
        if (expect_wr) exp_q.push_back({32'(cyc + 1), addr, rgb});
        tick();
        in_ena = 1'b0;
    endtask

    task automatic apply_tab(input string tag);
        foreach (tab[i]) begin
            drive_pix(tab[i].addr, tab[i].rgb, tab[i].exp_wr);
            chk($sformatf("%s_pix_count[%0d]", tag, i), 32'(pix_count), 32'(tab[i].exp_pix));
        end
    endtask

    task automatic fill_frame(input int n);
        tab.delete();
        for (int i = 0; i < n; i++)
            tab.push_back('{addr: 24'(i), rgb: 24'($urandom_range(0, 24'hFFFFFF)),
                            exp_wr: 1'b1, exp_pix: 24'(i + 1)});
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    // scoreboard: each expected write carries the cycle it must appear in
    always @(negedge pclk) begin
        logic [W-1:0] e;
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got write addr=%0h data=%0h cycle=%0d, required none",
                         wr_addr, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({32'(cyc), wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_stream: got cycle=%0d addr=%0h data=%0h required cycle=%0d addr=%0h data=%0h",
                             cyc, wr_addr, wr_data, e[79:48], e[47:24], e[23:0]);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0][79:48] <= 32'(cyc)) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL wr_missing: got no write at cycle %0d, required addr=%0h data=%0h",
                     cyc, e[47:24], e[23:0]);
        end
    end

    initial begin
        rstb = 1'b0; vsync = 1'b0; in_ena = 1'b0; in_addr = '0;
        in_r = '0; in_g = '0; in_b = '0;
        cap_req = 1'b0; cont_mode = 1'b0; frame_release = 1'b0;
        #2 rstb = 1'b1;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_ready", 32'(frame_ready), 0);
        chk("rst_pix_count", 32'(pix_count), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rstb = 1'b0;
        tick();

        // single capture; the pixel on the frame-start cycle is dropped
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        chk("s1_state_arm", 32'(state_dbg), 32'(ST_ARM));
        chk("s1_busy_arm", 32'(busy), 1);
        vsync = 1'b1;
        drive_pix(24'd0, 24'hABCDEF, 1'b0);
        chk("s1_state_cap", 32'(state_dbg), 32'(ST_CAP));
        chk("s1_pix_start", 32'(pix_count), 0);
        fill_frame(16);
        apply_tab("s1");
        chk("s1_frame_ready", 32'(frame_ready), 1);
        chk("s1_frame_cnt", 32'(frame_cnt), 1);
        chk("s1_busy", 32'(busy), 0);
        chk("s1_state_ready", 32'(state_dbg), 32'(ST_READY));

        // hold and release
        for (int i = 0; i < 5; i++) drive_pix(24'(i), 24'($urandom_range(0, 24'hFFFFFF)), 1'b0);
        chk("s2_hold_ready", 32'(frame_ready), 1);
        chk("s2_hold_pix", 32'(pix_count), 16);
        release_frame();
        chk("s2_rel_ready", 32'(frame_ready), 0);
        chk("s2_rel_state", 32'(state_dbg), 32'(ST_IDLE));
        release_frame();
        chk("s2_rel_ignored_idle", 32'(state_dbg), 32'(ST_IDLE));

        // short frame in continuous mode restarts capture
        vsync = 1'b0; cont_mode = 1'b1; tick();
        chk("s3_state_arm", 32'(state_dbg), 32'(ST_ARM));
        vsync = 1'b1; tick();
        fill_frame(10);
        apply_tab("s3a");
        vsync = 1'b0; tick();
        chk("s3_fall_no_fs", 32'(state_dbg), 32'(ST_CAP));
        chk("s3_fall_pix", 32'(pix_count), 10);
        vsync = 1'b1; tick();
        chk("s3_err_short", 32'(err_short), 1);
        chk("s3_restart_pix", 32'(pix_count), 0);
        chk("s3_restart_state", 32'(state_dbg), 32'(ST_CAP));
        fill_frame(16);
        apply_tab("s3b");
        chk("s3_frame_ready", 32'(frame_ready), 1);
        chk("s3_frame_cnt", 32'(frame_cnt), 2);
        chk("s3_err_sticky", 32'(err_short), 1);
        cont_mode = 1'b0;
        release_frame();
        chk("s3_rel_state", 32'(state_dbg), 32'(ST_IDLE));

        // address guard
        vsync = 1'b0; cap_req = 1'b1; tick(); cap_req = 1'b0;
        chk("s4_err_cleared", 32'(err_short), 0);
        vsync = 1'b1; tick();
        tab.delete();
        for (int i = 0; i < 8; i++)
            tab.push_back('{addr: 24'(i), rgb: 24'($urandom_range(0, 24'hFFFFFF)), exp_wr: 1'b1, exp_pix: 24'(i + 1)});
        tab.push_back('{addr: 24'd20, rgb: 24'h123456, exp_wr: 1'b0, exp_pix: 24'd8});
        for (int i = 8; i < 16; i++)
            tab.push_back('{addr: 24'(i), rgb: 24'($urandom_range(0, 24'hFFFFFF)), exp_wr: 1'b1, exp_pix: 24'(i + 1)});
        apply_tab("s4");
        chk("s4_frame_cnt", 32'(frame_cnt), 3);
        chk("s4_state_ready", 32'(state_dbg), 32'(ST_READY));
        release_frame();

        // timeout
        vsync = 1'b0; tick();
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        repeat (63) tick();
        chk("s5_still_arm", 32'(state_dbg), 32'(ST_ARM));
        chk("s5_no_err_yet", 32'(err_timeout), 0);
        tick();
        chk("s5_err_timeout", 32'(err_timeout), 1);
        chk("s5_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("s5_busy", 32'(busy), 0);

        // reset mid-capture
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        chk("s6_err_to_cleared", 32'(err_timeout), 0);
        vsync = 1'b1; tick();
        for (int i = 0; i < 7; i++) drive_pix(24'(i), 24'($urandom_range(0, 24'hFFFFFF)), 1'b1);
        chk("s6_pix_before", 32'(pix_count), 7);
        #1 rstb = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("s6_rst_wr_en", 32'(wr_en), 0);
        chk("s6_rst_wr_addr", 32'(wr_addr), 0);
        chk("s6_rst_wr_data", 32'(wr_data), 0);
        chk("s6_rst_pix", 32'(pix_count), 0);
        chk("s6_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        rstb = 1'b0;
        tick();
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        vsync = 1'b0; tick();
        vsync = 1'b1; tick();
        chk("s6_clean_state", 32'(state_dbg), 32'(ST_CAP));
        chk("s6_clean_pix", 32'(pix_count), 0);
        fill_frame(16);
        apply_tab("s6");
        chk("s6_frame_cnt", 32'(frame_cnt), 1);
        chk("s6_frame_ready", 32'(frame_ready), 1);

        // final report
        tick(); tick();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
